ddio_in_deser: RTL and testbench

DDIO_IN_DESER -- requirements
Module: ddio_in_deser

---
 rtl/ddio_in_deser.sv | 121 ++++++++++++
 tb/tb_ddio_in_deser.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddio_in_deser.sv
// DDR input deserializer: captures din on both clock edges and assembles WIDTH-bit words, MSB first.
// Optional bitslip alignment port is built only when DDIO_IN_BITSLIP_EN is defined.
module ddio_in_deser #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             rx_en,
`ifdef DDIO_IN_BITSLIP_EN
    input  logic             bitslip,
`endif
    output logic [WIDTH-1:0] word_data,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overflow
);

    localparam int unsigned Pairs = WIDTH / 2;
    localparam int unsigned CntW  = (Pairs > 1) ? $clog2(Pairs) : 1;

    logic             cap_r_q;
    logic             cap_f_q;
    logic             f_d_q;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [WIDTH-3:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic             slip;
    logic [1:0]       pair;
    logic [WIDTH-1:0] full_word;
    logic             complete;

`ifdef DDIO_IN_BITSLIP_EN
    assign slip = bitslip;
`else
    assign slip = 1'b0;
`endif

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            cap_f_q <= 1'b0;
        end else begin
            cap_f_q <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_r_q <= 1'b0;
            f_d_q   <= 1'b0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cap_r_q <= din;
            f_d_q   <= cap_f_q;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    // Phase 0 takes the falling sample straight from cap_f so a word is valid one edge after
    // its last falling bit; phase 1 pairs the older falling sample (f_d) with the rising one.
    assign pair      = phase_q ? {f_d_q, cap_r_q} : {cap_r_q, cap_f_q};
    assign full_word = {shreg_q, pair};

    always_comb begin
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        shreg_d  = shreg_q;
        complete = 1'b0;
        if (slip) begin
            phase_d = ~phase_q;
            cnt_d   = '0;
            shreg_d = '0;
        end else if (!rx_en) begin
            cnt_d   = '0;
            shreg_d = '0;
        end else begin
            shreg_d = full_word[WIDTH-3:0];
            if (cnt_q == CntW'(Pairs - 1)) begin
                complete = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (complete) begin
            if (!valid_q || word_ready) begin
                data_d  = full_word;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end
    end

    assign word_data  = data_q;
    assign word_valid = valid_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ddio_in_deser.sv
// Self-checking bench for ddio_in_deser (WIDTH=8): bit-queue reference model plus directed scenarios.
// Bitslip scenario is built only when DDIO_IN_BITSLIP_EN is defined.
module tb_ddio_in_deser;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         din;
    logic         rx_en;
    logic         word_ready;
`ifdef DDIO_IN_BITSLIP_EN
    logic         bitslip;
`endif
    logic [W-1:0] word_data;
    logic         word_valid;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic         tx[$];
    logic         hist[$];
    logic         asm_bits[$];
    logic         m_phase;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ovf;
    logic         pv;
    logic [W-1:0] got[$];
    int           got_cyc[$];

    always #5 clk = ~clk;

    ddio_in_deser #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .rx_en      (rx_en),
`ifdef DDIO_IN_BITSLIP_EN
        .bitslip    (bitslip),
`endif
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overflow   (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] gw(input int i);
        return (i < got.size()) ? {24'd0, got[i]} : 32'hxxxx_xxxx;
    endfunction

    function automatic int gc(input int i);
        return (i < got_cyc.size()) ? got_cyc[i] : -100;
    endfunction

    // Reference: bits collected since the last restart; a word is complete once W bits are in.
    task automatic model_edge(input logic rst, input logic en, input logic slip, input logic rdy,
                              input logic rs);
        logic         p0, p1;
        logic [W-1:0] w;
        bit           done;
        int           n;
        done = 0;
        w    = '0;
        n    = hist.size();
        if (!rst) begin
            asm_bits.delete();
            m_phase = 1'b0;
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            if (slip) begin
                m_phase = ~m_phase;
                asm_bits.delete();
            end else if (!en) begin
                asm_bits.delete();
            end else begin
                if (!m_phase) begin
                    p0 = hist[n-2];
                    p1 = hist[n-1];
                end else begin
                    p0 = hist[n-3];
                    p1 = hist[n-2];
                end
                asm_bits.push_back(p0);
                asm_bits.push_back(p1);
                if (asm_bits.size() == W) begin
                    foreach (asm_bits[i]) w = {w[W-2:0], asm_bits[i]};
                    asm_bits.delete();
                    done = 1;
                end
            end
            if (done) begin
                if (!m_valid || rdy) begin
                    m_data  = w;
                    m_valid = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
        hist.push_back(rst ? rs : 1'b0);
        while (hist.size() > 8) void'(hist.pop_front());
    endtask

    // One clock cycle: falling-edge bit, then rising-edge bit, then model update and compare.
    task automatic step(input logic bs_in);
        logic fb, rb;
        fb = (tx.size() > 0) ? tx.pop_front() : 1'b0;
        rb = (tx.size() > 0) ? tx.pop_front() : 1'b0;
        din = fb;
`ifdef DDIO_IN_BITSLIP_EN
        bitslip = bs_in;
`endif
        @(negedge clk);
        hist.push_back(rst_n ? fb : 1'b0);
        #1 din = rb;
        @(posedge clk);
        #1;
        model_edge(rst_n, rx_en, bs_in, word_ready, rb);
        chk("valid", {31'd0, word_valid}, {31'd0, m_valid});
        chk("data", {24'd0, word_data}, {24'd0, m_data});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (word_valid === 1'b1 && (!pv || word_ready)) begin
            got.push_back(word_data);
            got_cyc.push_back(cyc);
        end
        pv = (word_valid === 1'b1);
        cyc++;
    endtask

    task automatic send(input logic [31:0] bytes, input int nb);
        tx.push_back(1'b0);
        for (int i = 8 * nb - 1; i >= 0; i--) tx.push_back(bytes[i]);
        rx_en = 1'b0;
        step(1'b0);
        rx_en = 1'b1;
        while (tx.size() > 0) step(1'b0);
    endtask

    task automatic idle();
        rx_en = 1'b0;
        step(1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        rx_en      = 1'b0;
        word_ready = 1'b1;
        din        = 1'b0;
`ifdef DDIO_IN_BITSLIP_EN
        bitslip    = 1'b0;
`endif
        pv         = 1'b0;
        m_phase    = 1'b0;
        m_data     = '0;
        m_valid    = 1'b0;
        m_ovf      = 1'b0;
        repeat (3) hist.push_back(1'b0);

        step(1'b0);
        step(1'b0);
        chk("rst_valid", {31'd0, word_valid}, 32'd0);
        chk("rst_data", {24'd0, word_data}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;

        // Single word: valid on the edge right after the last falling bit, for one cycle.
        got.delete(); got_cyc.delete();
        send(32'hA5, 1);
        chk("a5_valid", {31'd0, word_valid}, 32'd1);
        chk("a5_data", {24'd0, word_data}, 32'hA5);
        idle();
        chk("a5_pulse_end", {31'd0, word_valid}, 32'd0);
        chk("a5_count", got.size(), 32'd1);

        // Back-to-back stream.
        got.delete(); got_cyc.delete();
        send(32'h3CC3FF, 3);
        idle();
        chk("b2b_count", got.size(), 32'd3);
        chk("b2b_w0", gw(0), 32'h3C);
        chk("b2b_w1", gw(1), 32'hC3);
        chk("b2b_w2", gw(2), 32'hFF);
        chk("b2b_gap01", gc(1) - gc(0), 32'd4);
        chk("b2b_gap12", gc(2) - gc(1), 32'd4);
        chk("b2b_ovf", {31'd0, overflow}, 32'd0);

        // Overflow: second word dropped while the first is held.
        word_ready = 1'b0;
        send(32'h1122, 2);
        chk("ovf_hold_data", {24'd0, word_data}, 32'h11);
        chk("ovf_hold_valid", {31'd0, word_valid}, 32'd1);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        word_ready = 1'b1;
        idle();
        chk("ovf_consumed", {31'd0, word_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Reset mid-word after two pairs of 0xF0.
        tx.push_back(1'b0);
        repeat (4) tx.push_back(1'b1);
        rx_en = 1'b0;
        step(1'b0);
        rx_en = 1'b1;
        step(1'b0);
        step(1'b0);
        rst_n = 1'b0;
        rx_en = 1'b0;
        step(1'b0);
        chk("mrst_data", {24'd0, word_data}, 32'd0);
        chk("mrst_valid", {31'd0, word_valid}, 32'd0);
        chk("mrst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        got.delete(); got_cyc.delete();
        send(32'h81, 1);
        idle();
        chk("mrst_count", got.size(), 32'd1);
        chk("mrst_word", gw(0), 32'h81);

        // rx_en dropped for one cycle mid-word.
        got.delete(); got_cyc.delete();
        tx.push_back(1'b0);
        tx.push_back(1'b1); tx.push_back(1'b0); tx.push_back(1'b1); tx.push_back(1'b1);
        rx_en = 1'b0;
        step(1'b0);
        rx_en = 1'b1;
        step(1'b0);
        step(1'b0);
        send(32'h96, 1);
        idle();
        chk("rxen_count", got.size(), 32'd1);
        chk("rxen_word", gw(0), 32'h96);

`ifdef DDIO_IN_BITSLIP_EN
        begin
            int gidx;
            got.delete(); got_cyc.delete();
            tx.push_back(1'b0);
            tx.push_back(1'b0);
            repeat (8) for (int i = 7; i >= 0; i--) tx.push_back(((8'h5A >> i) & 8'h01) != 0);
            rx_en = 1'b0;
            step(1'b0);
            rx_en = 1'b1;
            repeat (4) step(1'b0);
            step(1'b1);
            gidx = got.size();
            while (tx.size() > 0) step(1'b0);
            step(1'b0);
            step(1'b0);
            idle();
            chk("slip_count", got.size() - gidx, 32'd7);
            for (int i = gidx; i < got.size(); i++) chk("slip_word", gw(i), 32'h5A);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
